// File: rtl/dca_matrix_row_mover_if.sv
// Row-stream and matrix move-port bundle for dca_matrix_row_mover.
// The mover is the slave; the stream fabric and matrix model sit on the master side.
interface dca_matrix_row_mover_if #(
    parameter int unsigned BW_TENSOR_ROW = 256
);
    logic                     in_valid;
    logic                     in_ready;
    logic [BW_TENSOR_ROW-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [BW_TENSOR_ROW-1:0] out_data;
    logic                     move_wenable;
    logic [BW_TENSOR_ROW-1:0] move_wdata_list;
    logic                     move_renable;
    logic [BW_TENSOR_ROW-1:0] move_rdata_list;

    modport slave (
        input  in_valid, in_data, out_ready, move_rdata_list,
        output in_ready, out_valid, out_data, move_wenable, move_wdata_list, move_renable
    );

    modport master (
        output in_valid, in_data, out_ready, move_rdata_list,
        input  in_ready, out_valid, out_data, move_wenable, move_wdata_list, move_renable
    );
endinterface

// File: rtl/dca_matrix_row_mover.sv
// Row-stream controller for the move port of a row-granular DCA matrix register.
// LOAD writes one streamed row per beat; STORE pops rows to the output stream, optionally recirculating.
module dca_matrix_row_mover #(
    parameter int unsigned MATRIX_NUM_ROW   = 8,
    parameter int unsigned MATRIX_NUM_COL   = 8,
    parameter int unsigned BW_TENSOR_SCALAR = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 store_start,
    input  logic                 store_keep,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    dca_matrix_row_mover_if.slave bus
);
    localparam int unsigned BW_TENSOR_ROW = MATRIX_NUM_COL * BW_TENSOR_SCALAR;
    localparam int unsigned BW_ROW_COUNT  = $clog2(MATRIX_NUM_ROW) + 1;
    localparam logic [BW_ROW_COUNT-1:0] LAST_ROW = BW_ROW_COUNT'(MATRIX_NUM_ROW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_STORE = 2'd2
    } state_t;

    state_t                  state, state_d;
    logic [BW_ROW_COUNT-1:0] row_cnt, row_cnt_d;
    logic                    keep_q, keep_d;
    logic                    done_d;

    logic                     in_ready_c;
    logic                     out_valid_c;
    logic [BW_TENSOR_ROW-1:0] out_data_c;
    logic                     wen_c;
    logic [BW_TENSOR_ROW-1:0] wdata_c;
    logic                     ren_c;

    // State register; strobes derive from state so they drop as soon as rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            row_cnt <= '0;
            keep_q  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            row_cnt <= row_cnt_d;
            keep_q  <= keep_d;
            done    <= done_d;
        end
    end

    // Next-state and move/stream strobes; abort outranks a coincident beat.
    always_comb begin
        state_d     = state;
        row_cnt_d   = row_cnt;
        keep_d      = keep_q;
        done_d      = 1'b0;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        out_data_c  = '0;
        wen_c       = 1'b0;
        wdata_c     = '0;
        ren_c       = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (load_start) begin
                    state_d = S_LOAD;
                end else if (store_start) begin
                    state_d = S_STORE;
                    keep_d  = store_keep;
                end
            end

            S_LOAD: begin
                in_ready_c = 1'b1;
                if (abort) begin
                    state_d   = S_IDLE;
                    row_cnt_d = '0;
                    done_d    = 1'b1;
                end else if (bus.in_valid) begin
                    wen_c   = 1'b1;
                    wdata_c = bus.in_data;
                    if (row_cnt == LAST_ROW) begin
                        state_d   = S_IDLE;
                        row_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        row_cnt_d = row_cnt + BW_ROW_COUNT'(1);
                    end
                end
            end

            S_STORE: begin
                out_valid_c = 1'b1;
                out_data_c  = bus.move_rdata_list;
                if (abort) begin
                    state_d   = S_IDLE;
                    row_cnt_d = '0;
                    done_d    = 1'b1;
                end else if (bus.out_ready) begin
                    ren_c = 1'b1;
                    // Recirculate: the popped row is written back at the bottom.
                    if (keep_q) begin
                        wen_c   = 1'b1;
                        wdata_c = bus.move_rdata_list;
                    end
                    if (row_cnt == LAST_ROW) begin
                        state_d   = S_IDLE;
                        row_cnt_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        row_cnt_d = row_cnt + BW_ROW_COUNT'(1);
                    end
                end
            end

            default: begin
                state_d   = S_IDLE;
                row_cnt_d = '0;
            end
        endcase
    end

    assign busy                = (state != S_IDLE);
    assign bus.in_ready        = in_ready_c;
    assign bus.out_valid       = out_valid_c;
    assign bus.out_data        = out_data_c;
    assign bus.move_wenable    = wen_c;
    assign bus.move_wdata_list = wdata_c;
    assign bus.move_renable    = ren_c;
endmodule

// File: tb/tb_dca_matrix_row_mover.sv
// Directed bench for dca_matrix_row_mover with a behavioural shift-up matrix on the move port.
module tb_dca_matrix_row_mover;
    localparam int unsigned N  = 8;
    localparam int unsigned BW = 256;

    logic clk, rst;
    logic load_start, store_start, store_keep, abort;
    logic busy, done;

    dca_matrix_row_mover_if #(.BW_TENSOR_ROW(BW)) bus ();

    dca_matrix_row_mover #(
        .MATRIX_NUM_ROW(N), .MATRIX_NUM_COL(8), .BW_TENSOR_SCALAR(32)
    ) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .store_start(store_start),
        .store_keep(store_keep), .abort(abort),
        .busy(busy), .done(done),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            tag;
        logic          ls, ss, keep, ab, iv, ordy;
        logic [BW-1:0] idata;
        logic          e_ir, e_ov, e_wen, e_ren, e_busy, e_done;
        logic [BW-1:0] e_wdata, e_odata;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Matrix model: N rows, shift-up; pop upmost on renable, push downmost on wenable.
    logic [BW-1:0] mat[$];
    int wen_cnt = 0;
    int ren_cnt = 0;
    logic          s_wen, s_ren;
    logic [BW-1:0] s_wdata;

    initial bus.move_rdata_list = '0;
    always begin
        @(negedge clk);
        #3;
        s_wen   = bus.move_wenable;
        s_ren   = bus.move_renable;
        s_wdata = bus.move_wdata_list;
        @(posedge clk);
        if (s_ren) begin
            ren_cnt++;
            if (mat.size() > 0) void'(mat.pop_front());
        end
        if (s_wen) begin
            wen_cnt++;
            mat.push_back(s_wdata);
            if (mat.size() > N) void'(mat.pop_front());
        end
        bus.move_rdata_list = (mat.size() > 0) ? mat[0] : '0;
    end

    function automatic logic [BW-1:0] row(input int k);
        logic [BW-1:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = 32'h0000_0100 + 32'(k) + (32'(j) << 16);
        return r;
    endfunction

    function automatic vec_t mk(input int tag,
                                input logic ls, ss, keep, ab, iv, ordy,
                                input logic [BW-1:0] idata,
                                input logic e_ir, e_ov, e_wen, e_ren, e_busy, e_done,
                                input logic [BW-1:0] e_wdata, e_odata);
        vec_t v;
        v.tag = tag; v.ls = ls; v.ss = ss; v.keep = keep; v.ab = ab; v.iv = iv; v.ordy = ordy;
        v.idata = idata;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_wen = e_wen; v.e_ren = e_ren;
        v.e_busy = e_busy; v.e_done = e_done; v.e_wdata = e_wdata; v.e_odata = e_odata;
        return v;
    endfunction

    task automatic chk(input int tag, input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL v%0d %s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge, compare outputs 1 time unit later.
    task automatic apply(input vec_t v);
        @(negedge clk);
        load_start   = v.ls;
        store_start  = v.ss;
        store_keep   = v.keep;
        abort        = v.ab;
        bus.in_valid = v.iv;
        bus.in_data  = v.idata;
        bus.out_ready = v.ordy;
        #1;
        chk(v.tag, "in_ready",  BW'(bus.in_ready),     BW'(v.e_ir));
        chk(v.tag, "out_valid", BW'(bus.out_valid),    BW'(v.e_ov));
        chk(v.tag, "wenable",   BW'(bus.move_wenable), BW'(v.e_wen));
        chk(v.tag, "renable",   BW'(bus.move_renable), BW'(v.e_ren));
        chk(v.tag, "busy",      BW'(busy),             BW'(v.e_busy));
        chk(v.tag, "done",      BW'(done),             BW'(v.e_done));
        chk(v.tag, "wdata",     bus.move_wdata_list,   v.e_wdata);
        chk(v.tag, "out_data",  bus.out_data,          v.e_odata);
    endtask

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    vec_t seq[$];

    task automatic run(input vec_t q[$]);
        foreach (q[i]) apply(q[i]);
    endtask

    task automatic add_load(inout vec_t q[$], input int tag, input int base);
        for (int k = 0; k < N; k++)
            q.push_back(mk(tag + k, 0,0,0,0,1,0, row(base + k), 1,0,1,0,1,0, row(base + k), '0));
        q.push_back(mk(tag + 50, 0,0,0,0,0,0, '0, 0,0,0,0,0,1, '0, '0));
    endtask

    initial begin
        rst = 1'b1;
        load_start = 0; store_start = 0; store_keep = 0; abort = 0;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;

        // T1: load rows 0..7, then abort in IDLE must not pulse done.
        tbl_a.push_back(mk(100, 1,0,0,0,0,0, '0, 0,0,0,0,0,0, '0, '0));
        add_load(tbl_a, 101, 0);
        tbl_a.push_back(mk(160, 0,0,0,0,0,0, '0, 0,0,0,0,0,0, '0, '0));
        tbl_a.push_back(mk(161, 0,0,0,1,0,0, '0, 0,0,0,0,0,0, '0, '0));
        tbl_a.push_back(mk(162, 0,0,0,0,0,0, '0, 0,0,0,0,0,0, '0, '0));
        // T2: destructive store with out_ready toggling 1,0,...
        tbl_a.push_back(mk(200, 0,1,0,0,0,0, '0, 0,0,0,0,0,0, '0, '0));
        for (int c = 0; c < 15; c++) begin
            logic r;
            r = (c % 2 == 0);
            tbl_a.push_back(mk(201 + c, 0,0,0,0,0,r, '0, 0,1,0,r,1,0, '0,
                               row((c % 2 == 0) ? c / 2 : c / 2 + 1)));
        end
        tbl_a.push_back(mk(250, 0,0,0,0,0,0, '0, 0,0,0,0,0,1, '0, '0));
        // T3: reload, then recirculating store.
        tbl_a.push_back(mk(300, 1,0,0,0,0,0, '0, 0,0,0,0,0,0, '0, '0));
        add_load(tbl_a, 301, 0);
        tbl_a.push_back(mk(360, 0,1,1,0,0,0, '0, 0,0,0,0,0,0, '0, '0));
        for (int k = 0; k < N; k++)
            tbl_a.push_back(mk(361 + k, 0,0,0,0,0,1, '0, 0,1,1,1,1,0, row(k), row(k)));
        tbl_a.push_back(mk(390, 0,0,0,0,0,0, '0, 0,0,0,0,0,1, '0, '0));

        // T4: both starts together -> LOAD; a start mid-load is ignored.
        tbl_b.push_back(mk(400, 1,1,1,0,0,1, '0, 0,0,0,0,0,0, '0, '0));
        for (int k = 0; k < N; k++)
            tbl_b.push_back(mk(401 + k, 0,(k == 3),0,0,1,1, row(k), 1,0,1,0,1,0, row(k), '0));
        tbl_b.push_back(mk(450, 0,0,0,0,0,1, '0, 0,0,0,0,0,1, '0, '0));
        tbl_b.push_back(mk(451, 0,0,0,0,0,1, '0, 0,0,0,0,0,0, '0, '0));

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk(0, "rst in_ready",  BW'(bus.in_ready),     '0);
        chk(0, "rst out_valid", BW'(bus.out_valid),    '0);
        chk(0, "rst wenable",   BW'(bus.move_wenable), '0);
        chk(0, "rst renable",   BW'(bus.move_renable), '0);
        chk(0, "rst busy",      BW'(busy),             '0);
        chk(0, "rst done",      BW'(done),             '0);
        @(negedge clk);
        rst = 1'b0;

        run(tbl_a);
        chk(391, "matrix size", BW'(mat.size()), BW'(N));
        for (int k = 0; k < N; k++)
            if (k < mat.size()) chk(392 + k, "matrix row", mat[k], row(k));
        run(tbl_b);

        // T5: abort on the 3rd load beat, then a full load restarts from row 0.
        begin
            int w0;
            w0 = wen_cnt;
            seq.delete();
            seq.push_back(mk(500, 1,0,0,0,0,0, '0, 0,0,0,0,0,0, '0, '0));
            seq.push_back(mk(501, 0,0,0,0,1,0, row(20), 1,0,1,0,1,0, row(20), '0));
            seq.push_back(mk(502, 0,0,0,0,1,0, row(21), 1,0,1,0,1,0, row(21), '0));
            seq.push_back(mk(503, 0,0,0,1,1,0, row(22), 1,0,0,0,1,0, '0, '0));
            seq.push_back(mk(504, 0,0,0,0,0,0, '0, 0,0,0,0,0,1, '0, '0));
            run(seq);
            @(negedge clk);
            chk(505, "abort wen count", BW'(wen_cnt - w0), BW'(2));
            seq.delete();
            seq.push_back(mk(510, 1,0,0,0,0,0, '0, 0,0,0,0,0,0, '0, '0));
            add_load(seq, 511, 0);
            run(seq);
        end

        // T6: rst mid-store after 4 beats, then a fresh full store.
        begin
            int r0;
            seq.delete();
            seq.push_back(mk(600, 0,1,1,0,0,0, '0, 0,0,0,0,0,0, '0, '0));
            for (int k = 0; k < 4; k++)
                seq.push_back(mk(601 + k, 0,0,0,0,0,1, '0, 0,1,1,1,1,0, row(k), row(k)));
            run(seq);
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk(610, "rst out_valid", BW'(bus.out_valid),    '0);
            chk(611, "rst renable",   BW'(bus.move_renable), '0);
            chk(612, "rst wenable",   BW'(bus.move_wenable), '0);
            chk(613, "rst busy",      BW'(busy),             '0);
            chk(614, "rst done",      BW'(done),             '0);
            @(negedge clk);
            rst = 1'b0;
            r0 = ren_cnt;
            seq.delete();
            seq.push_back(mk(620, 0,1,1,0,0,1, '0, 0,0,0,0,0,0, '0, '0));
            for (int k = 0; k < N; k++)
                seq.push_back(mk(621 + k, 0,0,0,0,0,1, '0, 0,1,1,1,1,0,
                                 row((k + 4) % N), row((k + 4) % N)));
            seq.push_back(mk(650, 0,0,0,0,0,0, '0, 0,0,0,0,0,1, '0, '0));
            run(seq);
            chk(651, "store ren count", BW'(ren_cnt - r0), BW'(N));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
